// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Elastic pipeline-register chain for inter-stage boundaries (ID/EX, EX/MEM, ...).
//   Carries a DATA_W datapath bundle and a CTRL_W control bundle through DEPTH
//   register stages. Each stage has its own valid bit. The chain supports
//   valid/ready backpressure, a global stall and a flush. The control output is
//   forced to BUBBLE_CTRL whenever the output slot is empty. This means squashed
//   slots never present live RegWr/MemWr bits downstream.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   in_valid   upstream slot valid
//   in_ready   chain accepts in_* this cycle
//   in_data    upstream datapath bundle   [DATA_W]
//   in_ctrl    upstream control bundle    [CTRL_W]
//   out_valid  last stage holds a valid slot
//   out_ready  downstream accepts this cycle
//   out_data   last-stage datapath bundle (driven regardless of valid)
//   out_ctrl   last-stage control, BUBBLE_CTRL when invalid
//   stall      global hold: nothing moves, no transfer in or out
//   flush      squash every slot (priority over everything but reset)
//   occupancy  number of valid stages, 0..DEPTH
module pipe_stage_chain #(
  parameter int                 DATA_W      = 32,
  parameter int                 CTRL_W      = 10,
  parameter int                 DEPTH       = 2,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [3:0]        occupancy
);

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be within 1..8");
  end

  // Occupancy update for one cycle. Accept-in and accept-out in the same cycle cancel.
  function automatic logic [3:0] occ_next(input logic [3:0] occ,
                                          input logic       inc,
                                          input logic       dec);
    logic [3:0] res;
    res = occ;
    if (inc && !dec) res = occ + 4'd1;
    else if (dec && !inc) res = occ - 4'd1;
    return res;
  endfunction

  logic              vld_p  [DEPTH];
  logic [DATA_W-1:0] data_p [DEPTH];
  logic [CTRL_W-1:0] ctrl_p [DEPTH];
  // Unpacked so each element's ripple dependency is seen as a separate net.
  logic              rdy    [DEPTH];

  logic rdy_out;
  logic in_acc;
  logic out_acc;

  assign rdy_out  = out_ready & ~stall;
  // Held low while in reset so nothing is offered a handshake during reset.
  assign in_ready = rdy[0] & ~flush & reset;
  assign in_acc   = in_valid & in_ready;
  assign out_acc  = vld_p[DEPTH-1] & rdy_out;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              src_vld;
    logic [DATA_W-1:0] src_data;
    logic [CTRL_W-1:0] src_ctrl;

    if (i == 0) begin : g_head
      assign src_vld  = in_acc;
      assign src_data = in_data;
      assign src_ctrl = in_ctrl;
    end else begin : g_body
      assign src_vld  = vld_p[i-1];
      assign src_data = data_p[i-1];
      assign src_ctrl = ctrl_p[i-1];
    end

    // A stage can take a new slot if it is empty or its own slot moves on.
    // The result ripples back from the output combinationally, so no bubble is wasted.
    // Stall gates every stage, including an empty output stage.
    if (i == DEPTH - 1) begin : g_tail_rdy
      assign rdy[i] = (~vld_p[i] | rdy_out) & ~stall;
    end else begin : g_mid_rdy
      assign rdy[i] = (~vld_p[i] | rdy[i+1]) & ~stall;
    end

    // ---- stage i register boundary ----
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
        ctrl_p[i] <= '0;
      end else if (flush) begin
        vld_p[i] <= 1'b0;
      end else if (rdy[i]) begin
        vld_p[i] <= src_vld;
        // An empty slot moving in leaves the payload untouched.
        if (src_vld) begin
          data_p[i] <= src_data;
          ctrl_p[i] <= src_ctrl;
        end
      end
    end
  end

  // ---- occupancy register boundary ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= 4'd0;
    end else if (flush) begin
      occupancy <= 4'd0;
    end else begin
      occupancy <= occ_next(occupancy, in_acc, out_acc);
    end
  end

  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1];
  assign out_ctrl  = vld_p[DEPTH-1] ? ctrl_p[DEPTH-1] : BUBBLE_CTRL;

endmodule
